// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Brief    : Four-digit multiplexed common-anode seven-segment driver with
//            per-frame input shadowing, leading-zero blanking and edit blink.
// Revision : 1.0
// ============================================================================
module seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    input  logic [3:0] x3,
    input  logic [3:0] x4,
    input  logic [3:0] sel,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] c_blank = 7'b1111111;
    localparam logic [6:0] c_dash  = 7'b0111111;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [FW-1:0] r_fcnt;
    logic          r_ph;
    logic          r_live;
    logic [3:0]    r_s1, r_s2, r_s3, r_s4;
    logic [3:0]    r_sel;
    logic          r_blz;

    logic          w_fs;
    logic          w_wrap;
    logic          w_fwrap;
    logic [3:0]    w_s1_n, w_s2_n, w_s3_n, w_s4_n;
    logic [3:0]    w_sel_n;
    logic          w_blz_n;
    logic          w_ph_n;
    logic          w_onehot;
    logic          w_selected;
    logic          w_lead_zero;
    logic [3:0]    w_digit;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg;

    assign w_fs    = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_wrap  = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_fwrap = (r_fcnt == FW'(BLINK_DIV - 1));

    // Values in force for the slot being registered this edge; on a frame
    // start they are the freshly captured ones so a whole frame is coherent.
    assign w_s1_n  = w_fs ? x1 : r_s1;
    assign w_s2_n  = w_fs ? x2 : r_s2;
    assign w_s3_n  = w_fs ? x3 : r_s3;
    assign w_s4_n  = w_fs ? x4 : r_s4;
    assign w_sel_n = w_fs ? sel : r_sel;
    assign w_blz_n = w_fs ? blank_lz : r_blz;
    assign w_ph_n  = (w_fs && w_fwrap) ? ~r_ph : r_ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= 2'd0;
            r_fcnt <= '0;
            r_ph   <= 1'b1;
            r_live <= 1'b0;
            r_s1   <= 4'd0;
            r_s2   <= 4'd0;
            r_s3   <= 4'd0;
            r_s4   <= 4'd0;
            r_sel  <= 4'd0;
            r_blz  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_s1   <= w_s1_n;
            r_s2   <= w_s2_n;
            r_s3   <= w_s3_n;
            r_s4   <= w_s4_n;
            r_sel  <= w_sel_n;
            r_blz  <= w_blz_n;
            r_ph   <= w_ph_n;
            if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fs) begin
                r_fcnt <= w_fwrap ? '0 : r_fcnt + FW'(1);
            end
        end
    end

    assign w_onehot   = (w_sel_n != 4'd0) && ((w_sel_n & (w_sel_n - 4'd1)) == 4'd0);
    assign w_selected = w_onehot && w_sel_n[r_idx];

    always_comb begin
        w_digit     = w_s1_n;
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit     = w_s1_n;
                w_lead_zero = (w_s1_n == 4'd0);
            end
            2'd1: begin
                w_digit     = w_s2_n;
                w_lead_zero = (w_s1_n == 4'd0) && (w_s2_n == 4'd0);
            end
            2'd2: begin
                w_digit     = w_s3_n;
                w_lead_zero = (w_s1_n == 4'd0) && (w_s2_n == 4'd0) && (w_s3_n == 4'd0);
            end
            default: begin
                // Least significant digit is never blanked as a leading zero.
                w_digit     = w_s4_n;
                w_lead_zero = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_glyph = c_dash;
        case (w_digit)
            4'd0:    w_glyph = 7'b1000000;
            4'd1:    w_glyph = 7'b1111001;
            4'd2:    w_glyph = 7'b0100100;
            4'd3:    w_glyph = 7'b0110000;
            4'd4:    w_glyph = 7'b0011001;
            4'd5:    w_glyph = 7'b0010010;
            4'd6:    w_glyph = 7'b0000010;
            4'd7:    w_glyph = 7'b1111000;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0010000;
            default: w_glyph = c_dash;
        endcase
    end

    always_comb begin
        w_seg = w_glyph;
        if (w_selected && !w_ph_n) begin
            w_seg = c_blank;
        end else if (w_blz_n && w_lead_zero) begin
            w_seg = c_blank;
        end
    end

    // The first edge out of reset only loads shadows; the display lights
    // from the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= c_blank;
            dp  <= 1'b1;
        end else if (!r_live) begin
            an  <= 4'b1111;
            seg <= c_blank;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b1000 >> r_idx);
            seg <= w_seg;
            dp  <= ~w_selected;
        end
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Four-digit multiplexed seven-segment display driver that consumes the four BCD digit registers produced by the switch/button digit-entry stage and drives the board's common-anode display. It time-multiplexes the digits, blanks leading zeros on request, blinks the digit currently selected for editing, and samples its inputs once per frame so a digit never changes mid-frame.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays lit (≥2).
- BLINK_DIV, 128: full frames per blink half-period (≥1).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- x1  in  4  digit 1 (most significant), BCD 0-9.
- x2  in  4  digit 2.
- x3  in  4  digit 3.
- x4  in  4  digit 4 (least significant).
- sel  in  4  edit-select switches; sel[0]↔x1 … sel[3]↔x4.
- blank_lz  in  1  1 = blank leading zeros.
- an  out  4  anodes, active-low; an[3]=x1 position … an[0]=x4 position.
- seg  out  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.

## Operation
- Scan counter cnt: 0..SCAN_DIV-1, wraps; on wrap, digit index idx advances 0→1→2→3→0. idx i shows digit x(i+1) on an[3-i].
- Frame start = cnt==0 and idx==0. On that edge, shadows s1..s4 ← x1..x4, sel_s ← sel, blz_s ← blank_lz. All display decisions use shadows only.
- Blink: frame counter increments at each frame start; when it reaches BLINK_DIV it clears and blink phase ph toggles. ph=1 visible, ph=0 hidden.
- Selection valid only when sel_s is exactly one-hot; otherwise no digit is selected (no blink, no dp).
- Digit content for current idx, priority order:
  - selected digit and ph=0 → blank;
  - blz_s=1, digit is zero, every more-significant shadow is zero, and digit is not x4 → blank (x4 never blanked);
  - value 0-9 → normal glyph;
  - value 10-15 → dash (g only).
- Glyphs (seg): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- an = one-hot-low for current idx always, even when content is blank.
- dp = 0 when the current digit is the selected digit (independent of ph), else 1.

## Timing
- Reset (async): cnt=0, idx=0, frame counter=0, ph=1, shadows=0, sel_s=0, blz_s=0; an=1111, seg=1111111, dp=1.
- First clock edge after rst deasserts is a frame start: shadows load.
- an/seg/dp are registered from idx/cnt/shadows of the previous cycle: one-cycle latency. The second edge after reset shows idx 0 (an=0111).
- Each digit is displayed for exactly SCAN_DIV cycles; frame = 4·SCAN_DIV cycles; blink half-period = BLINK_DIV frames.
- Input changes mid-frame have no visible effect until the next frame start; a change that coincides with the frame-start edge is captured.
- rst asserted mid-frame: outputs immediately go dark (an=1111) and all state returns to reset values, regardless of clk.

## Test plan
- SCAN_DIV=4, BLINK_DIV=2; reset; x1..x4=1,2,3,4, sel=0, blank_lz=0 → an cycles 0111,1011,1101,1110, 4 cycles each; seg 1111001,0100100,0110000,0011001; dp=1 throughout.
- x=0,0,0,7, blank_lz=1 → first three positions seg=1111111, x4 shows 1111000; x=0,0,0,0 → only x4 shows 1000000; blank_lz=0 → all four show 0.
- sel=0010, x=5,5,5,5 → x2 position has dp=0 every frame; its seg alternates 0010010 for 2 frames and 1111111 for 2 frames; other digits steady; sel=0011 → no blink, dp=1 everywhere.
- x3=12 → x3 position shows 0111111 (dash).
- Change x1 from 1 to 8 while idx=2 → x1 position still shows 1 for the remainder of that frame, 8 from the next frame.
- Assert rst for 3 cycles during idx=2 → an=1111, seg=1111111, dp=1 asynchronously; after release, scan restarts at idx 0 with new shadows.
